// File: rtl/id_stage_if.sv
// ============================================================
// Module  : id_stage_if
// Brief   : IF->ID->EX bus of the decode stage (fetch handshake, regfile
//           read, ID/EX payload, writeback retire, flush).
//           IDU_ILLEGAL_EN adds the illegal flag.
// Rev     : 1.0
// ============================================================
`default_nettype none

interface id_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [31:0]           in_inst;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [3:0]            alu_ctr;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] store_data;
  logic [4:0]            rd;
  logic                  reg_we;
  logic [1:0]            wb_sel;
  logic                  mem_re;
  logic                  mem_we;
  logic [2:0]            mem_op;
  logic [2:0]            br_type;
  logic                  ebreak;
`ifdef IDU_ILLEGAL_EN
  logic                  illegal;
`endif
  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic                  flush;

  modport slave (
    input  in_valid, in_pc, in_inst, rs1_data, rs2_data, out_ready,
           wb_valid, wb_rd, flush,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_pc, alu_a, alu_b,
           alu_ctr, imm, store_data, rd, reg_we, wb_sel, mem_re, mem_we,
           mem_op, br_type,
`ifdef IDU_ILLEGAL_EN
    output illegal,
`endif
    output ebreak
  );

  modport master (
    output in_valid, in_pc, in_inst, rs1_data, rs2_data, out_ready,
           wb_valid, wb_rd, flush,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_pc, alu_a, alu_b,
           alu_ctr, imm, store_data, rd, reg_we, wb_sel, mem_re, mem_we,
           mem_op, br_type,
`ifdef IDU_ILLEGAL_EN
    input  illegal,
`endif
    input  ebreak
  );
endinterface

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================
// Module  : id_stage
// Brief   : RV32I decode, operand/ALUctr select, ID/EX register and RAW
//           scoreboard. IDU_ILLEGAL_EN enables the illegal output.
// Rev     : 1.0
// ============================================================
`default_nettype none

module id_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  id_stage_if.slave  bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] store_data;
    logic [3:0]            alu_ctr;
    logic [4:0]            rd;
    logic                  reg_we;
    logic [1:0]            wb_sel;
    logic                  mem_re;
    logic                  mem_we;
    logic [2:0]            mem_op;
    logic [2:0]            br_type;
    logic                  ebreak;
  } idex_t;

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? 4'b1000 : 4'b0000;
      3'b001:  code = 4'b0001;
      3'b010:  code = 4'b0010;
      3'b011:  code = 4'b1010;
      3'b100:  code = 4'b0100;
      3'b101:  code = alt ? 4'b1101 : 4'b0101;
      3'b110:  code = 4'b0110;
      default: code = 4'b0111;
    endcase
    return code;
  endfunction

  logic [31:0]           inst;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [4:0]            rd_f;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  idex_t                 dec;
  logic                  dec_ill, dec_wr, use_rs1, use_rs2;
  logic                  stall, accept;
  idex_t                 idex_d, idex_q;
  logic                  out_valid_d, out_valid_q;
  logic [31:0]           busy_d, busy_q;

  assign inst  = bus.in_inst;
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign rd_f  = inst[11:7];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt = {{(DATA_WIDTH-5){1'b0}}, inst[24:20]};

  assign bus.rs1_addr = inst[19:15];
  assign bus.rs2_addr = inst[24:20];

  always_comb begin
    dec     = '0;
    dec.pc  = bus.in_pc;
    dec_ill = 1'b0;
    dec_wr  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (inst[6:0])
      OPC_LUI: begin
        dec.alu_b = imm_u; dec.imm = imm_u; dec.alu_ctr = 4'b0011; dec_wr = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_a = bus.in_pc; dec.alu_b = imm_u; dec.imm = imm_u; dec_wr = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.alu_a   = bus.in_pc;
        dec.alu_b   = DATA_WIDTH'(4);
        dec.wb_sel  = 2'b10;
        dec_wr      = 1'b1;
        if (inst[3]) begin
          dec.imm = imm_j; dec.br_type = 3'b010;
        end else begin
          dec.imm = imm_i; dec.br_type = 3'b011; use_rs1 = 1'b1;
          dec_ill = (f3 != 3'b000);
        end
      end
      OPC_BRANCH: begin
        dec.alu_a = bus.rs1_data; dec.alu_b = bus.rs2_data; dec.imm = imm_b;
        dec.br_type = 3'b001; dec.mem_op = f3; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3[2:1])
          2'b00:   dec.alu_ctr = 4'b1000;
          2'b10:   dec.alu_ctr = 4'b0010;
          2'b11:   dec.alu_ctr = 4'b1010;
          default: dec_ill     = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.alu_a = bus.rs1_data; dec.alu_b = imm_i; dec.imm = imm_i;
        dec.mem_re = 1'b1; dec.mem_op = f3; dec.wb_sel = 2'b01;
        dec_wr = 1'b1; use_rs1 = 1'b1;
        dec_ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.alu_a = bus.rs1_data; dec.alu_b = imm_s; dec.imm = imm_s;
        dec.mem_we = 1'b1; dec.mem_op = f3; dec.store_data = bus.rs2_data;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec_ill = f3[2] || (f3 == 3'b011);
      end
      OPC_OPIMM: begin
        // Only srai honours inst[30]; for addi it is just an immediate bit.
        dec.alu_a   = bus.rs1_data;
        dec.imm     = imm_i;
        dec.alu_ctr = alu_fn(f3, inst[30] && (f3 == 3'b101));
        dec.alu_b   = (f3[1:0] == 2'b01) ? shamt : imm_i;
        dec_wr      = 1'b1;
        use_rs1     = 1'b1;
        dec_ill     = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                      ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      OPC_OP: begin
        dec.alu_a = bus.rs1_data; dec.alu_b = bus.rs2_data;
        dec.alu_ctr = alu_fn(f3, inst[30]);
        dec_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec_ill = !((f7 == 7'h00) ||
                    ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if (inst == INST_EBREAK) dec.ebreak = 1'b1;
        else if (inst != INST_ECALL) dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec.mem_re = 1'b0; dec.mem_we = 1'b0; dec.br_type = 3'b000;
      dec.wb_sel = 2'b00; dec.ebreak = 1'b0;
      dec_wr = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    end
    dec.reg_we = dec_wr && (rd_f != 5'd0);
    dec.rd     = dec.reg_we ? rd_f : 5'd0;
  end

  assign stall  = bus.in_valid && ((use_rs1 && busy_q[bus.rs1_addr]) ||
                                   (use_rs2 && busy_q[bus.rs2_addr]));
  assign bus.in_ready = !bus.flush && !stall && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    idex_d      = accept ? dec : idex_q;
    out_valid_d = out_valid_q;
    if (accept)                           out_valid_d = 1'b1;
    else if (bus.out_ready || bus.flush)  out_valid_d = 1'b0;

    busy_d = busy_q;
    if (bus.wb_valid) busy_d[bus.wb_rd] = 1'b0;
    // A dropped instruction will never retire, so release its claim here.
    if (bus.flush && out_valid_q && !bus.out_ready && idex_q.reg_we)
      busy_d[idex_q.rd] = 1'b0;
    if (accept && dec.reg_we) busy_d[dec.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      idex_q      <= idex_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef IDU_ILLEGAL_EN
  logic illegal_d, illegal_q;
  assign illegal_d = accept ? dec_ill : illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign bus.illegal = illegal_q;
`endif

  assign bus.out_valid  = out_valid_q;
  assign bus.out_pc     = idex_q.pc;
  assign bus.alu_a      = idex_q.alu_a;
  assign bus.alu_b      = idex_q.alu_b;
  assign bus.alu_ctr    = idex_q.alu_ctr;
  assign bus.imm        = idex_q.imm;
  assign bus.store_data = idex_q.store_data;
  assign bus.rd         = idex_q.rd;
  assign bus.reg_we     = idex_q.reg_we;
  assign bus.wb_sel     = idex_q.wb_sel;
  assign bus.mem_re     = idex_q.mem_re;
  assign bus.mem_we     = idex_q.mem_we;
  assign bus.mem_op     = idex_q.mem_op;
  assign bus.br_type    = idex_q.br_type;
  assign bus.ebreak     = idex_q.ebreak;
endmodule

`default_nettype wire

// File: doc/id_stage.md
# id_stage

Decode stage of the 4-stage RV32I core, producing the operand and `ALUctr` stream that the EX-stage ALU consumes. It takes fetched instructions over a valid/ready handshake, reads the register file, and selects ALU operands A/B and the 4-bit ALU control code. It registers all of this into the ID/EX pipeline register. A register scoreboard holds back read-after-write hazards until writeback retires the producer.

## Interface
Parameters:
- `DATA_WIDTH`: from `define.v`, 32. Operand and PC width.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `in_valid`  in  1  — IF offers an instruction.
- `in_ready`  out  1  — ID accepts this cycle.
- `in_pc`  in  32  — PC of the offered instruction.
- `in_inst`  in  32  — instruction word.
- `rs1_addr`, `rs2_addr`  out  5  — combinational from `in_inst[19:15]` and `in_inst[24:20]`.
- `rs1_data`, `rs2_data`  in  32  — register-file read data, same cycle.
- `out_valid`  out  1  — ID/EX register holds an instruction.
- `out_ready`  in  1  — EX takes it this cycle.
- `out_pc`  out  32  — PC of the held instruction.
- `alu_a`, `alu_b`  out  32  — ALU operands.
- `alu_ctr`  out  4  — ALU operation code.
- `imm`  out  32  — sign-extended immediate, used for branch/jump targets.
- `store_data`  out  32  — `rs2_data` for stores.
- `rd`  out  5  — destination register.
- `reg_we`  out  1  — destination write enable; forced to 0 when `rd == 0`.
- `wb_sel`  out  2  — writeback source: 00 ALU, 01 memory, 10 pc+4.
- `mem_re`, `mem_we`  out  1  — load / store.
- `mem_op`  out  3  — funct3 of the load or store.
- `br_type`  out  3  — 000 none, 001 branch (funct3 in `mem_op`), 010 jal, 011 jalr.
- `ebreak`  out  1  — instruction is EBREAK (simulation halt).
- `illegal`  out  1  — present only with `IDU_ILLEGAL_EN`.
- `wb_valid`  in  1  — writeback retires a register write.
- `wb_rd`  in  5  — register being retired.
- `flush`  in  1  — EX redirect; squash younger work.

## Operation
ALU codes: 0000 add, 1000 sub, 0001 sll, 0010 slt, 1010 sltu, 0011 pass B, 0100 xor, 0110 or, 0111 and, 0101 srl, 1101 sra.

Decode by opcode:
- **LUI**: A=0, B=imm_U, ctr 0011.
- **AUIPC**: A=pc, B=imm_U, add.
- **JAL / JALR**: A=pc, B=4, add, `wb_sel`=10; imm_J or imm_I.
- **BEQ/BNE**: A=rs1, B=rs2, sub. **BLT/BGE**: slt. **BLTU/BGEU**: sltu. EX uses the ALU Zero/Less flags.
- **Loads / stores**: A=rs1, B=imm_I or imm_S, add.
- **OP-IMM / OP**: funct3 plus `inst[30]` map directly onto the ALU codes.
  - `inst[30]` selects sub only for OP.
  - `inst[30]` selects sra for both OP and OP-IMM.
  - Shift amount is carried in `B[4:0]`.
- **FENCE, ECALL**: NOP (`reg_we`=0, `br_type`=0).
- **EBREAK**: NOP with `ebreak`=1.

Scoreboard:
- 32-bit `busy` vector; bit 0 is never set.
- Set for `rd` when an instruction with `reg_we`=1 is accepted.
- Cleared when `wb_valid` && `wb_rd` match.
- The same register set and cleared in one cycle: set wins.
- Stall when `in_valid` and a source register that the instruction actually uses is busy.
- Rs2 is used by OP, branches and stores only.

Handshake:
- `in_ready` = !flush && !stall && (!out_valid || out_ready).
- Transfer on `in_valid && in_ready`.

## Timing
- Reset (async, on `rst_n` low): `out_valid`=0, every registered output 0, `busy`=0. `in_ready` is 1 once `rst_n` is high, provided there is no hazard.
- Latency: an instruction accepted at edge N appears with `out_valid`=1 after edge N.
- Throughput: 1 instruction per cycle when there are no hazards.
- Output stall: held output stays stable while `out_valid && !out_ready`.
- Scoreboard clear is not bypassed. An instruction stalled on register r proceeds in the cycle after `wb_valid`/`wb_rd`=r.
- `flush` cycle: nothing is accepted.
  - If the held instruction is not transferred this cycle, it is dropped (`out_valid`=0 next cycle).
  - If it had set a busy bit, that bit is cleared.
  - An instruction transferred the same cycle is kept.
- `rst_n` asserted mid-stall: all state clears immediately. No pending hazard survives.

## Configuration
- `IDU_ILLEGAL_EN` defined: the `illegal` port exists.
  - Unknown opcode or invalid funct3/funct7 yields `illegal`=1.
  - The instruction is forced to NOP (`reg_we`=0, `mem_*`=0, `br_type`=0).
  - It still flows through the handshake.
- Not defined: no `illegal` port. Unknown encodings decode as NOP silently.

## Test plan
- **ADDI**: reset, then `addi x5,x0,-1` (0xFFF00293) → one cycle later `out_valid`=1, `alu_a`=0, `alu_b`=0xFFFFFFFF, `alu_ctr`=0000, `rd`=5, `reg_we`=1.
- **Back-to-back RAW**: `addi x1,x0,3` then `add x2,x1,x1`.
  - Second instruction stalls (`in_ready`=0) until `wb_valid`=1, `wb_rd`=1.
  - Accepted the following cycle with `alu_ctr`=0000.
- **Output hold**: `out_ready`=0 for 3 cycles holding `sra` (`alu_ctr`=1101) → outputs stable, `in_ready`=0; a pulse on `out_ready` releases it.
- **Branch / LUI**: `bltu x3,x4,+8` → `alu_ctr`=1010, `br_type`=001, `imm`=8, `reg_we`=0. `lui x7,0x12345` → `alu_b`=0x12345000, `alu_ctr`=0011.
- **Flush**: held `addi x9` with `out_ready`=0, then `flush`=1 → `out_valid`=0 next cycle, `busy[9]`=0. A following `add x10,x9,x9` issues without stall.
- **Illegal** (with `IDU_ILLEGAL_EN`): 0x0000007F → `illegal`=1, `reg_we`=0. Without the macro, the same word gives a NOP.
